// File: rtl/serial_bus_top.sv
// Board-level serial-bus demo: configures two masters from switches/keys, moves words
// to/from three slave memories, then displays master memory. HEX digits gated by HEX_DISPLAY_EN.
module serial_bus_top #(
    parameter int unsigned SLAVE_COUNT                   = 3,
    parameter int unsigned MASTER_COUNT                  = 2,
    parameter int unsigned DATA_WIDTH                    = 16,
    parameter int unsigned SLAVE_DEPTHS [0:SLAVE_COUNT-1] = '{4096, 4096, 2048},
    parameter int unsigned MAX_MASTER_WRITE_DEPTH        = 16
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [17:0] LEDR,
    output logic [3:0]  LEDG,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_RS,
    output logic        LCD_BLON,
    output logic        LCD_ON
);
    localparam int unsigned MD = SLAVE_DEPTHS[0];
    localparam int unsigned AW = $clog2(MD);
    localparam int unsigned PW = $clog2(MAX_MASTER_WRITE_DEPTH);

    typedef enum logic [3:0] {
        S_SLAVE_SEL, S_RW_SEL, S_EXT_SEL, S_EXT_M1, S_EXT_M2, S_ADDR_M1, S_ADDR_M2,
        S_CNT_M1, S_CNT_M2, S_CONFIG, S_READY, S_COMM, S_DONE, S_DISPLAY
    } state_t;

    state_t                  r_state, w_state_next;
    logic [1:0]              r_sync1, r_sync2, r_sync3;
    logic                    w_ps, w_pa, w_ext_wr, w_last, r_cfg_cnt, r_job;
    logic [1:0]              r_slave [MASTER_COUNT];
    logic [AW-1:0]           r_start [MASTER_COUNT];
    logic [AW-1:0]           r_count [MASTER_COUNT];
    logic [MASTER_COUNT-1:0] r_op, r_ext, w_act;
    logic [PW-1:0]           r_ptr;
    logic [AW-1:0]           r_view, r_idx, w_saddr;
    logic [1:0]              w_sidx;
    logic [DATA_WIDTH-1:0]   w_m_rdata, w_s_rdata, w_m1_word;
    logic [17:0]             r_ledr;
    logic [3:0]              r_ledg;
    logic                    w_unused_keys;

    // Slave words are stored XORed with their power-up pattern so an all-zero array reads back as (id<<12)|addr.
    logic [DATA_WIDTH-1:0] r_mem_m [MASTER_COUNT][MD] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_mem_s [SLAVE_COUNT][MD]  = '{default: '0};

    function automatic logic [DATA_WIDTH-1:0] slave_init(input logic [1:0] sidx, input logic [AW-1:0] a);
        slave_init = (DATA_WIDTH'(32'(sidx) + 32'd1) << 12) | DATA_WIDTH'(a);
    endfunction

    function automatic logic [AW-1:0] wrap_addr(input logic [1:0] sidx, input logic [AW:0] sum);
        wrap_addr = '0;
        for (int unsigned s = 0; s < SLAVE_COUNT; s++)
            if (32'(sidx) == s) wrap_addr = AW'(32'(sum) % SLAVE_DEPTHS[s]);
    endfunction

    assign w_unused_keys = ^{KEY[0], KEY[3]};
    assign w_ps          = r_sync3[0] & ~r_sync2[0];
    assign w_pa          = r_sync3[1] & ~r_sync2[1];
    assign w_last        = (r_idx == r_count[r_job] - AW'(1));
    assign w_sidx        = r_slave[r_job] - 2'd1;
    assign w_saddr       = wrap_addr(w_sidx, {1'b0, r_start[r_job]} + {1'b0, r_idx});
    assign w_m_rdata     = r_mem_m[r_job][r_idx];
    assign w_s_rdata     = r_mem_s[w_sidx][w_saddr] ^ slave_init(w_sidx, w_saddr);
    assign w_m1_word     = r_mem_m[0][r_view];

    always_comb begin
        w_act = '0;
        for (int m = 0; m < MASTER_COUNT; m++)
            w_act[m] = (r_slave[m] != 2'd0) && (r_count[m] != '0);
    end

    // KEY[2:1] synchronizers plus edge register; released level is 1.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_sync3 <= '1;
        end else begin
            r_sync1 <= KEY[2:1];
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) r_state <= S_SLAVE_SEL;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ext_wr     = 1'b0;
        case (r_state)
            S_SLAVE_SEL: if (w_ps) w_state_next = S_RW_SEL;
            S_RW_SEL:    if (w_ps) w_state_next = S_EXT_SEL;
            S_EXT_SEL:   if (w_ps) w_state_next = SW[0] ? S_EXT_M1 : (SW[1] ? S_EXT_M2 : S_ADDR_M1);
            S_EXT_M1: begin
                w_ext_wr = w_ps | w_pa;
                if (w_ps) w_state_next = r_ext[1] ? S_EXT_M2 : S_ADDR_M1;
            end
            S_EXT_M2: begin
                w_ext_wr = w_ps | w_pa;
                if (w_ps) w_state_next = S_ADDR_M1;
            end
            S_ADDR_M1:   if (w_ps) w_state_next = S_ADDR_M2;
            S_ADDR_M2:   if (w_ps) w_state_next = S_CNT_M1;
            S_CNT_M1:    if (w_ps) w_state_next = S_CNT_M2;
            S_CNT_M2:    if (w_ps) w_state_next = S_CONFIG;
            S_CONFIG:    if (r_cfg_cnt) w_state_next = S_READY;
            S_READY:     if (w_ps) w_state_next = (w_act != '0) ? S_COMM : S_DONE;
            S_COMM:      if (w_last && !(!r_job && w_act[1])) w_state_next = S_DONE;
            S_DONE:      if (w_ps) w_state_next = S_DISPLAY;
            S_DISPLAY:   if (w_ps) w_state_next = S_SLAVE_SEL;
            default:     w_state_next = S_SLAVE_SEL;
        endcase
    end

    // Configuration latches, load pointer and transfer sequencing.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_slave   <= '{default: '0};
            r_start   <= '{default: '0};
            r_count   <= '{default: '0};
            r_op      <= '0;
            r_ext     <= '0;
            r_ptr     <= '0;
            r_view    <= '0;
            r_job     <= 1'b0;
            r_idx     <= '0;
            r_cfg_cnt <= 1'b0;
        end else begin
            r_cfg_cnt <= (r_state == S_CONFIG);
            if (w_state_next != r_state)
                r_ptr <= '0;
            else if (w_ext_wr && w_pa && r_ptr != PW'(MAX_MASTER_WRITE_DEPTH - 1))
                r_ptr <= r_ptr + PW'(1);
            if (w_ps) begin
                case (r_state)
                    S_SLAVE_SEL: begin
                        r_slave[0] <= SW[1:0];
                        r_slave[1] <= SW[3:2];
                    end
                    S_RW_SEL:  r_op       <= SW[1:0];
                    S_EXT_SEL: r_ext      <= SW[1:0];
                    S_ADDR_M1: r_start[0] <= SW[AW-1:0];
                    S_ADDR_M2: r_start[1] <= SW[AW-1:0];
                    S_CNT_M1:  r_count[0] <= SW[AW-1:0];
                    S_CNT_M2:  r_count[1] <= SW[AW-1:0];
                    S_READY: begin
                        r_job <= ~w_act[0];
                        r_idx <= '0;
                    end
                    S_DONE:    r_view     <= SW[AW-1:0];
                    default: ;
                endcase
            end
            if (r_state == S_COMM) begin
                if (w_last) begin
                    r_job <= 1'b1;
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + AW'(1);
                end
            end
        end
    end

    // Memories keep their contents across rst; writes are suppressed during it.
    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            if (w_ext_wr)
                r_mem_m[r_state == S_EXT_M2][AW'(r_ptr)] <= SW[DATA_WIDTH-1:0];
            else if (r_state == S_COMM) begin
                if (r_op[r_job]) r_mem_s[w_sidx][w_saddr] <= w_m_rdata ^ slave_init(w_sidx, w_saddr);
                else             r_mem_m[r_job][r_idx]    <= w_s_rdata;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_ledr <= SW;
            r_ledg <= '0;
        end else begin
            r_ledr <= (r_state == S_DISPLAY) ? 18'(w_m1_word) : SW;
            r_ledg <= {r_state == S_COMM, r_state == S_DONE, r_state == S_READY,
                       (r_state == S_EXT_M1) || (r_state == S_EXT_M2)};
        end
    end

    assign LEDR     = r_ledr;
    assign LEDG     = r_ledg;
    assign LCD_DATA = 8'h00;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = 1'b0;
    assign LCD_RS   = 1'b0;
    assign LCD_BLON = 1'b1;
    assign LCD_ON   = 1'b1;

`ifdef HEX_DISPLAY_EN
    logic [6:0]            r_hex [8];
    logic [DATA_WIDTH-1:0] w_m2_word;
    assign w_m2_word = r_mem_m[1][r_view];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_hex <= '{default: 7'h7F};
        end else begin
            r_hex <= '{default: 7'h7F};
            if (r_state == S_DISPLAY) begin
                for (int i = 0; i < 4; i++) begin
                    r_hex[i]   <= seg7(w_m1_word[4*i +: 4]);
                    r_hex[i+4] <= seg7(w_m2_word[4*i +: 4]);
                end
            end else begin
                r_hex[0] <= seg7(4'(r_state));
            end
        end
    end

    assign HEX0 = r_hex[0];
    assign HEX1 = r_hex[1];
    assign HEX2 = r_hex[2];
    assign HEX3 = r_hex[3];
    assign HEX4 = r_hex[4];
    assign HEX5 = r_hex[5];
    assign HEX6 = r_hex[6];
    assign HEX7 = r_hex[7];
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign HEX6 = 7'h7F;
    assign HEX7 = 7'h7F;
`endif
endmodule

// File: tb/tb_serial_bus_top.sv
// Directed bench for serial_bus_top: four full configure/run/display passes with hand-computed results.
module tb_serial_bus_top;
    logic        CLOCK_50 = 1'b0;
    logic        rst;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [17:0] LEDR;
    logic [3:0]  LEDG;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [7:0]  LCD_DATA;
    logic        LCD_RW, LCD_EN, LCD_RS, LCD_BLON, LCD_ON;

    int n_vec = 0;
    int n_err = 0;

    serial_bus_top dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .KEY(KEY), .SW(SW), .LEDR(LEDR), .LEDG(LEDG),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7),
        .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
        .LCD_BLON(LCD_BLON), .LCD_ON(LCD_ON)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef HEX_DISPLAY_EN
    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        seg = tbl[v];
    endfunction

    function automatic logic [27:0] seg_word(input logic [15:0] w);
        seg_word = {seg(w[15:12]), seg(w[11:8]), seg(w[7:4]), seg(w[3:0])};
    endfunction
`endif

    // One key press: low for 4 cycles, then released and allowed to settle.
    task automatic press(input int k, input logic [17:0] sw);
        SW = sw;
        @(negedge CLOCK_50);
        KEY[k] = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        KEY[k] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    // READY press that also measures how many cycles LEDG[3] stays high before LEDG[2].
    task automatic run_comm(input string tag, input int exp_busy);
        int busy;
        bit done;
        busy = 0;
        done = 1'b0;
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge CLOCK_50);
            if (c == 4) KEY[1] = 1'b1;
            if (LEDG[3]) busy++;
            if (LEDG[2]) done = 1'b1;
        end
        KEY[1] = 1'b1;
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(busy), 64'(exp_busy));
        chk({tag, "_done_ledg"}, 64'(LEDG), 64'h4);
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic chk_display(input string tag, input logic [15:0] m1, input logic [15:0] m2);
        chk({tag, "_ledr"}, 64'(LEDR), 64'(m1));
`ifdef HEX_DISPLAY_EN
        chk({tag, "_hex_m1"}, 64'({HEX3, HEX2, HEX1, HEX0}), 64'(seg_word(m1)));
        chk({tag, "_hex_m2"}, 64'({HEX7, HEX6, HEX5, HEX4}), 64'(seg_word(m2)));
`else
        chk({tag, "_hex_off"}, 64'({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}),
            64'h00FF_FFFF_FFFF_FFFF);
        chk({tag, "_m2_unused"}, 64'(m2 & 16'h0), 64'h0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        KEY = 4'hF;
        SW  = 18'h00005;
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_ledg", 64'(LEDG), 64'h0);
        chk("rst_ledr", 64'(LEDR), 64'h00005);
        chk("lcd_const", 64'({LCD_DATA, LCD_RW, LCD_EN, LCD_RS, LCD_BLON, LCD_ON}), 64'h003);
`ifdef HEX_DISPLAY_EN
        chk("rst_hex0_state", 64'(HEX0), 64'h40);
        chk("rst_hex7_blank", 64'(HEX7), 64'h7F);
`else
        chk("rst_hex_off", 64'({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'h00FF_FFFF_FFFF_FFFF);
`endif

        // Pass 1: M1 slave1 write, M2 slave2 read, both preloaded, addr 1/1, count 1/1
        press(1, 18'h00009);
`ifdef HEX_DISPLAY_EN
        chk("p1_hex0_rwsel", 64'(HEX0), 64'h79);
`endif
        press(1, 18'h00001);
        press(1, 18'h00003);
        chk("p1_ext_m1_ledg", 64'(LEDG), 64'h1);
        chk("p1_ext_ledr_sw", 64'(LEDR), 64'h00003);
        press(2, 18'h01234);
        press(1, 18'h0ABCD);
        chk("p1_ext_m2_ledg", 64'(LEDG), 64'h1);
        press(1, 18'h05555);
        chk("p1_addr_ledg", 64'(LEDG), 64'h0);
        press(1, 18'h00001);
        press(1, 18'h00001);
        press(1, 18'h00001);
        press(1, 18'h00001);
        chk("p1_ready_ledg", 64'(LEDG), 64'h2);
        run_comm("p1", 2);
        press(1, 18'h00000);
        chk_display("p1_view0", 16'h1234, 16'h2001);
        press(1, 18'h00000);
        chk("p1_back_ledg", 64'(LEDG), 64'h0);
        chk("p1_back_ledr", 64'(LEDR), 64'h00000);

        // Pass 2: M1 reads back slave1[1]; M2 reads slave3 from 2047 for 2 words (wraps)
        press(1, 18'h0000D);
        press(1, 18'h00000);
        press(1, 18'h00001);
        press(1, 18'h00000);
        press(1, 18'h00001);
        press(1, 18'h007FF);
        press(1, 18'h00001);
        press(1, 18'h00002);
        chk("p2_ready_ledg", 64'(LEDG), 64'h2);
        run_comm("p2", 3);
        press(1, 18'h00000);
        chk_display("p2_view0", 16'h1234, 16'h37FF);
        press(1, 18'h00000);

        // Pass 3: M1 slave3 wrap read, M2 slave 0 (skipped despite count 5), no preload
        press(1, 18'h00003);
        press(1, 18'h00000);
        press(1, 18'h00000);
        chk("p3_no_ext_ledg", 64'(LEDG), 64'h0);
        press(1, 18'h007FF);
        press(1, 18'h00000);
        press(1, 18'h00002);
        press(1, 18'h00005);
        run_comm("p3", 2);
        press(1, 18'h00001);
        chk_display("p3_view1", 16'h3000, 16'h3000);
        press(1, 18'h00000);

        // Pass 4: 20 loads saturate the pointer at 15, then both jobs skipped
        press(1, 18'h00000);
        press(1, 18'h00000);
        press(1, 18'h00001);
        for (int k = 0; k < 20; k++) press(2, 18'(32'h100 + k));
        chk("p4_ext_still", 64'(LEDG), 64'h1);
        press(1, 18'h0BEEF);
        press(1, 18'h00000);
        press(1, 18'h00000);
        press(1, 18'h00003);
        press(1, 18'h00003);
        chk("p4_ready_ledg", 64'(LEDG), 64'h2);
        run_comm("p4", 0);
        press(1, 18'h0000F);
        chk_display("p4_view15", 16'hBEEF, 16'h0000);
        press(1, 18'h0000E);
        press(1, 18'h00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
